relm_ps2_rx: RTL



---
 rtl/relm_ps2_rx.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/relm_ps2_rx.sv
// ----------------------------------------------------------------------------
// relm_ps2_rx
//   Hardware PS/2 receive stage for the relm keyboard pop port. The raw PS/2
//   clock and data pins are synchronised and glitch-filtered. Each 11-bit
//   device-to-host frame is deserialised and its start, parity and stop bits
//   are checked. Received bytes are queued in a show-ahead FIFO that the CPU
//   drains through a standard relm pop-port pair.
//
// Ports
//   clk            system clock
//   rst            synchronous reset, active-high
//   ps2_clk_in     raw PS/2 clock pin (asynchronous)
//   ps2_dat_in     raw PS/2 data pin (asynchronous)
//   pop_d_in       pop request from relm; bit WD is the pop strobe
//   pop_q_out      {retry(empty), zeros, ovf, perr, byte[7:0]}
//   frame_err_out  one-cycle pulse on a bad stop bit or a mid-frame timeout
// ----------------------------------------------------------------------------
module relm_ps2_rx #(
   parameter int WD      = 32,
   parameter int WAD     = 4,
   parameter int WF      = 8,
   parameter int TIMEOUT = 50000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ps2_clk_in,
   input  logic          ps2_dat_in,
   input  logic [WD:0]   pop_d_in,
   output logic [WD:0]   pop_q_out,
   output logic          frame_err_out
);

   localparam int TW = $clog2(TIMEOUT);
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RECV = 1'b1;

   // ---------------- input path: synchroniser + hysteresis filter ----------
   logic [1:0]    clk_s_q, clk_s_d, dat_s_q, dat_s_d;
   logic [WF-1:0] clk_sh_q, clk_sh_d, dat_sh_q, dat_sh_d;
   logic          clk_f_q, clk_f_d, dat_f_q, dat_f_d;

   // ---------------- receiver ----------------------------------------------
   logic [0:0]    state_q, state_d;
   logic [3:0]    bitcnt_q, bitcnt_d;
   logic [9:0]    shift_q, shift_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          wr_q, wr_d;
   logic [8:0]    wr_data_q, wr_data_d;
   logic          err_q, err_d;
   logic          fall, sample, perr;

   // ---------------- FIFO --------------------------------------------------
   logic [WAD:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic          ovf_q, ovf_d;
   logic [8:0]    mem_q [2**WAD];
   logic          empty, full, pop_go, wr_go;
   logic [8:0]    head;

   // Lower pop-request bits carry no meaning for this port.
   logic          unused_bits;
   assign unused_bits = ^{pop_d_in[WD-1:0], shift_q[0]};

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves
      // it unassigned; otherwise synthesis infers a latch.
      clk_s_d  = {clk_s_q[0], ps2_clk_in};
      dat_s_d  = {dat_s_q[0], ps2_dat_in};
      clk_sh_d = {clk_sh_q[WF-2:0], clk_s_q[1]};
      dat_sh_d = {dat_sh_q[WF-2:0], dat_s_q[1]};
      // Filtered level moves only when the whole window agrees, else holds.
      clk_f_d  = (&clk_sh_q) ? 1'b1 : (~|clk_sh_q) ? 1'b0 : clk_f_q;
      dat_f_d  = (&dat_sh_q) ? 1'b1 : (~|dat_sh_q) ? 1'b0 : dat_f_q;
   end

   // A fall is the cycle in which the filtered clock commits from 1 to 0.
   assign fall   = clk_f_q & ~clk_f_d;
   assign sample = dat_f_q;
   // After nine shifts: [8:1] = data (bit 0 at [1]), [9] = parity.
   assign perr   = ~(^shift_q[8:1] ^ shift_q[9]);

   always_comb begin
      state_d   = state_q;
      bitcnt_d  = bitcnt_q;
      shift_d   = shift_q;
      tmo_d     = tmo_q;
      wr_d      = 1'b0;
      wr_data_d = wr_data_q;
      err_d     = 1'b0;
      if (state_q == ST_IDLE) begin
         tmo_d = '0;
         if (fall && !sample) begin
            state_d  = ST_RECV;
            bitcnt_d = 4'd1;
         end
      end else if (tmo_q == TW'(TIMEOUT - 1)) begin
         // Timeout wins over a coincident fall; the partial frame is dropped.
         state_d  = ST_IDLE;
         bitcnt_d = 4'd0;
         tmo_d    = '0;
         err_d    = 1'b1;
      end else if (fall) begin
         tmo_d = '0;
         if (bitcnt_q == 4'd10) begin
            state_d  = ST_IDLE;
            bitcnt_d = 4'd0;
            if (sample) begin
               wr_d      = 1'b1;
               wr_data_d = {perr, shift_q[8:1]};
            end else begin
               err_d = 1'b1;
            end
         end else begin
            shift_d  = {sample, shift_q[9:1]};
            bitcnt_d = bitcnt_q + 4'd1;
         end
      end else begin
         tmo_d = tmo_q + TW'(1);
      end
   end

   assign empty  = (wr_ptr_q == rd_ptr_q);
   assign full   = (wr_ptr_q[WAD] != rd_ptr_q[WAD]) &&
                   (wr_ptr_q[WAD-1:0] == rd_ptr_q[WAD-1:0]);
   assign pop_go = pop_d_in[WD] & ~empty;
   // A pop frees the head slot in the same cycle, so a full FIFO still accepts.
   assign wr_go  = wr_q & (~full | pop_go);
   assign head   = mem_q[rd_ptr_q[WAD-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q + (WAD+1)'(wr_go);
      rd_ptr_d = rd_ptr_q + (WAD+1)'(pop_go);
      ovf_d    = ovf_q;
      if (wr_q && !wr_go) ovf_d = 1'b1;
      else if (pop_go)    ovf_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      // NOTE: state updates use <= so every flop samples pre-edge values,
      // independent of the order statements appear in.
      if (rst) begin
         clk_s_q   <= '1;
         dat_s_q   <= '1;
         clk_sh_q  <= '1;
         dat_sh_q  <= '1;
         clk_f_q   <= 1'b1;
         dat_f_q   <= 1'b1;
         state_q   <= ST_IDLE;
         bitcnt_q  <= '0;
         shift_q   <= '0;
         tmo_q     <= '0;
         wr_q      <= 1'b0;
         wr_data_q <= '0;
         err_q     <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         ovf_q     <= 1'b0;
      end else begin
         clk_s_q   <= clk_s_d;
         dat_s_q   <= dat_s_d;
         clk_sh_q  <= clk_sh_d;
         dat_sh_q  <= dat_sh_d;
         clk_f_q   <= clk_f_d;
         dat_f_q   <= dat_f_d;
         state_q   <= state_d;
         bitcnt_q  <= bitcnt_d;
         shift_q   <= shift_d;
         tmo_q     <= tmo_d;
         wr_q      <= wr_d;
         wr_data_q <= wr_data_d;
         err_q     <= err_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         ovf_q     <= ovf_d;
      end
   end

   // NOTE: storage is not reset; the pointers alone define which entries are
   // valid, and leaving the array reset-free lets it map onto RAM.
   always_ff @(posedge clk) begin
      if (wr_go) mem_q[wr_ptr_q[WAD-1:0]] <= wr_data_q;
   end

   assign pop_q_out     = {empty, {(WD-10){1'b0}}, ovf_q, empty ? 9'd0 : head};
   assign frame_err_out = err_q;

endmodule
